// File: rtl/mdu_ctrl.sv
// -----------------------------------------------------------------------------
// mdu_ctrl
//
// Multi-cycle multiply/divide sequencer for the E stage.
// An accepted mult/multu/div/divu computes its result at the start edge and
// holds it in pending registers. After a fixed busy period the pending value
// is committed to HI/LO. mthi/mtlo write HI/LO directly in one cycle.
// The block also raises the stall that holds the D stage while an MDU
// instruction there would collide with an operation in flight.
//
// Optional feature macro: MDU_FAST_MULT_EN
//   defined   : mult/multu commit at the start edge with no busy period
//   undefined : mult/multu run MULT_CYCLES busy cycles (default build)
//
// Parameters
//   MULT_CYCLES  busy cycles for mult/multu (1..31)
//   DIV_CYCLES   busy cycles for div/divu   (1..31)
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   start      in   E-stage instruction is mult/multu/div/divu
//   E_MDU_OP   in   1 multu, 2 mult, 3 divu, 4 div, 5 mthi, 6 mtlo, 0 none
//   E_RD1      in   rs operand
//   E_RD2      in   rt operand
//   E_AO_S     in   read select: 1 LO, 2 HI, otherwise 0
//   D_mdu_use  in   D-stage instruction is an MDU instruction
//   busy       out  operation in flight (state is BUSY)
//   stall      out  hold D and bubble E
//   HI, LO     out  committed HI/LO
//   E_MDU_OUT  out  read data to the EX result mux (committed regs only)
//
// Handshake: start is a single-cycle request with no ready. It is taken only
// in IDLE; a start (or mthi/mtlo) seen in BUSY is dropped. The stall output
// keeps a legal pipeline from ever presenting one in BUSY.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module mdu_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  E_MDU_OP,
   input  logic [31:0] E_RD1,
   input  logic [31:0] E_RD2,
   input  logic [3:0]  E_AO_S,
   input  logic        D_mdu_use,
   output logic        busy,
   output logic        stall,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic [31:0] E_MDU_OUT
);

   localparam logic [3:0] OP_MULTU = 4'd1;
   localparam logic [3:0] OP_MULT  = 4'd2;
   localparam logic [3:0] OP_DIVU  = 4'd3;
   localparam logic [3:0] OP_DIV   = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;

   localparam logic [3:0] SEL_LO   = 4'd1;
   localparam logic [3:0] SEL_HI   = 4'd2;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [4:0]  r_cnt;
   logic [31:0] r_hi;
   logic [31:0] r_lo;
   logic [31:0] r_pend_hi;
   logic [31:0] r_pend_lo;
   logic        r_pend_we;

   // ---------------------------------------------------------------------------
   // Operation decode
   // ---------------------------------------------------------------------------
   logic w_is_mult;
   logic w_is_div;
   logic w_div_zero;

   assign w_is_mult  = (E_MDU_OP == OP_MULT) || (E_MDU_OP == OP_MULTU);
   assign w_is_div   = (E_MDU_OP == OP_DIV)  || (E_MDU_OP == OP_DIVU);
   assign w_div_zero = (E_RD2 == 32'd0);

   // ---------------------------------------------------------------------------
   // Multiplier: both operands are widened to 64 bits (sign- or zero-extended);
   // the low 64 bits of the product are then correct for either signedness.
   // ---------------------------------------------------------------------------
   logic [63:0] w_mul_a;
   logic [63:0] w_mul_b;
   logic [63:0] w_prod;

   assign w_mul_a = (E_MDU_OP == OP_MULT) ? {{32{E_RD1[31]}}, E_RD1} : {32'd0, E_RD1};
   assign w_mul_b = (E_MDU_OP == OP_MULT) ? {{32{E_RD2[31]}}, E_RD2} : {32'd0, E_RD2};
   assign w_prod  = w_mul_a * w_mul_b;

   // ---------------------------------------------------------------------------
   // Divider: one unsigned divider serves both div and divu. For div the
   // operands are converted to magnitudes and the signs are restored after:
   // the quotient is negative when the operand signs differ (truncation toward
   // zero), the remainder takes the sign of the dividend.
   // A zero divisor is replaced by 1 only to keep the divider output defined;
   // that result is never committed.
   // ---------------------------------------------------------------------------
   logic        w_rs_neg;
   logic        w_rt_neg;
   logic [31:0] w_dvd;
   logic [31:0] w_dvs_mag;
   logic [31:0] w_dvs;
   logic [31:0] w_quo_mag;
   logic [31:0] w_rem_mag;
   logic [31:0] w_quo;
   logic [31:0] w_rem;

   assign w_rs_neg  = (E_MDU_OP == OP_DIV) & E_RD1[31];
   assign w_rt_neg  = (E_MDU_OP == OP_DIV) & E_RD2[31];
   assign w_dvd     = w_rs_neg ? (~E_RD1 + 32'd1) : E_RD1;
   assign w_dvs_mag = w_rt_neg ? (~E_RD2 + 32'd1) : E_RD2;
   assign w_dvs     = w_div_zero ? 32'd1 : w_dvs_mag;
   assign w_quo_mag = w_dvd / w_dvs;
   assign w_rem_mag = w_dvd % w_dvs;
   assign w_quo     = (w_rs_neg ^ w_rt_neg) ? (~w_quo_mag + 32'd1) : w_quo_mag;
   assign w_rem     = w_rs_neg ? (~w_rem_mag + 32'd1) : w_rem_mag;

   // ---------------------------------------------------------------------------
   // Result selection
   // ---------------------------------------------------------------------------
   logic [31:0] w_res_hi;
   logic [31:0] w_res_lo;
   logic        w_res_we;

   assign w_res_hi = w_is_mult ? w_prod[63:32] : w_rem;
   assign w_res_lo = w_is_mult ? w_prod[31:0]  : w_quo;
   // Divide by zero still runs its busy period but leaves HI/LO untouched.
   assign w_res_we = w_is_mult | (w_is_div & ~w_div_zero);

   // ---------------------------------------------------------------------------
   // Acceptance and commit conditions
   // ---------------------------------------------------------------------------
   logic       w_accept;
   logic       w_launch;
   logic       w_fast_commit;
   logic       w_last;
   logic [4:0] w_load_cnt;

   assign w_accept = (r_state == S_IDLE) & start & (w_is_mult | w_is_div);

`ifdef MDU_FAST_MULT_EN
   assign w_launch      = w_accept & w_is_div;
   assign w_fast_commit = w_accept & w_is_mult;
`else
   assign w_launch      = w_accept;
   assign w_fast_commit = 1'b0;
`endif

   assign w_load_cnt = w_is_div ? 5'(DIV_CYCLES) : 5'(MULT_CYCLES);

   // Commit when the counter is at 1. Testing <= 1 also brings the FSM home if
   // the counter were ever 0 in BUSY, so it can never lock up.
   assign w_last = (r_state == S_BUSY) && (r_cnt <= 5'd1);

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next state
   // ---------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_launch) begin
               w_state_nxt = S_BUSY;
            end
         end
         S_BUSY: begin
            if (w_last) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM: outputs (purely combinational, no output register)
   // ---------------------------------------------------------------------------
   always_comb begin
      busy      = (r_state == S_BUSY);
      stall     = D_mdu_use & (start | (r_state == S_BUSY));
      E_MDU_OUT = 32'd0;
      case (E_AO_S)
         SEL_LO:  E_MDU_OUT = r_lo;
         SEL_HI:  E_MDU_OUT = r_hi;
         default: E_MDU_OUT = 32'd0;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Counter, pending result and HI/LO
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt     <= 5'd0;
         r_hi      <= 32'd0;
         r_lo      <= 32'd0;
         r_pend_hi <= 32'd0;
         r_pend_lo <= 32'd0;
         r_pend_we <= 1'b0;
      end else begin
         if (w_launch) begin
            r_cnt     <= w_load_cnt;
            r_pend_hi <= w_res_hi;
            r_pend_lo <= w_res_lo;
            r_pend_we <= w_res_we;
         end else if (r_state == S_BUSY) begin
            // Inputs are ignored here: a stray start or mthi/mtlo is dropped.
            r_cnt <= r_cnt - 5'd1;
            if (w_last && r_pend_we) begin
               r_hi <= r_pend_hi;
               r_lo <= r_pend_lo;
            end
         end else if (w_fast_commit) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
         end else if (E_MDU_OP == OP_MTHI) begin
            r_hi <= E_RD1;
         end else if (E_MDU_OP == OP_MTLO) begin
            r_lo <= E_RD1;
         end
      end
   end

   assign HI = r_hi;
   assign LO = r_lo;

endmodule
